output_port_tracker: RTL and testbench

- Transmit-side counterpart of a router input port; one instance sits per output port, between the crossbar and the physical link.
- Registers the crossbar flit onto the link and tracks downstream per-VC on/off status.
- Runs a per-VC ownership FSM for the downstream input port, giving the VC allocator the free downstream VCs and the switch allocator the sendable VCs.
- Flags link-protocol violations.

---
 rtl/output_port_tracker_pkg.sv | 52 +++++
 rtl/output_port_tracker_if.sv | 38 +++
 rtl/output_port_tracker_downstream_vc_tracker.sv | 110 +++++++++++
 rtl/output_port_tracker.sv | 83 ++++++++
 tb/tb_output_port_tracker.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/output_port_tracker_pkg.sv
// -----------------------------------------------------------------------------
// output_port_tracker_pkg
// Shared NoC types for the transmit side of a router output port:
//   VC_NUM / VC_SIZE      : number of virtual channels and VC id width
//   flit_label_t          : HEAD, BODY, TAIL, HEADTAIL
//   flit_t                : packed flit {label, vc_id, payload}
//   downstream_vc_state_t : ownership state of one downstream input VC
//   multi_hot()           : true when more than one bit of a VC vector is set
// -----------------------------------------------------------------------------
package output_port_tracker_pkg;

   localparam int VC_NUM      = 2;
   localparam int VC_SIZE     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
   localparam int FLIT_DATA_W = 16;

   typedef enum logic [1:0] {
      HEAD     = 2'd0,
      BODY     = 2'd1,
      TAIL     = 2'd2,
      HEADTAIL = 2'd3
   } flit_label_t;

   typedef struct packed {
      flit_label_t              flit_label;
      logic [VC_SIZE-1:0]       vc_id;
      logic [FLIT_DATA_W-1:0]   data;
   } flit_t;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      RESERVED     = 2'd1,
      ACTIVE       = 2'd2,
      WAIT_RELEASE = 2'd3
   } downstream_vc_state_t;

   // Bit-serial scan instead of a popcount: the block is meant to be free of
   // arithmetic, and a VC vector is only a handful of bits wide.
   function automatic logic multi_hot(input logic [VC_NUM-1:0] vec);
      logic found;
      logic multi;
      found = 1'b0;
      multi = 1'b0;
      for (int i = 0; i < VC_NUM; i++) begin
         if (vec[i]) begin
            if (found) multi = 1'b1;
            found = 1'b1;
         end
      end
      return multi;
   endfunction

endpackage

// File: rtl/output_port_tracker_if.sv
// -----------------------------------------------------------------------------
// output_port_tracker_if
// Bundle between crossbar/allocators/link and one output_port_tracker.
// Signal names keep the tracker's point of view (_i into it, _o out of it).
//   flit_i, valid_i          : crossbar flit and its valid (SA grant)
//   va_grant_i               : one-hot VC-allocator reservation of a downstream VC
//   on_off_i, allocatable_i  : downstream per-VC credit-less status
//   data_o, valid_flit_o     : link flit and valid
//   vc_allocatable_o         : downstream VCs free for VA
//   vc_ready_o               : downstream VCs the SA may send on
//   error_o                  : sticky per-VC protocol error
// Modports: master = environment side, slave = tracker side.
// -----------------------------------------------------------------------------
interface output_port_tracker_if;
   import output_port_tracker_pkg::*;

   flit_t               flit_i;
   logic                valid_i;
   logic [VC_NUM-1:0]   va_grant_i;
   logic [VC_NUM-1:0]   on_off_i;
   logic [VC_NUM-1:0]   allocatable_i;
   flit_t               data_o;
   logic                valid_flit_o;
   logic [VC_NUM-1:0]   vc_allocatable_o;
   logic [VC_NUM-1:0]   vc_ready_o;
   logic [VC_NUM-1:0]   error_o;

   modport master (
      output flit_i, valid_i, va_grant_i, on_off_i, allocatable_i,
      input  data_o, valid_flit_o, vc_allocatable_o, vc_ready_o, error_o
   );

   modport slave (
      input  flit_i, valid_i, va_grant_i, on_off_i, allocatable_i,
      output data_o, valid_flit_o, vc_allocatable_o, vc_ready_o, error_o
   );

endinterface

// File: rtl/output_port_tracker_downstream_vc_tracker.sv
// -----------------------------------------------------------------------------
// downstream_vc_tracker
// Ownership tracker for one downstream input VC.
//   clk, rst     : clock, synchronous active-high reset
//   grant        : VA reserved this VC this cycle
//   grant_multi  : the VA grant vector this cycle was not one-hot
//   flit_hit     : a valid flit addressed to this VC is on the crossbar
//   label        : label of that flit
//   on_off       : raw downstream on/off for this VC
//   allocatable  : raw downstream allocatable for this VC
//   free         : VC is IDLE, offered to the VC allocator
//   ready        : VC is RESERVED/ACTIVE and downstream is on
//   error        : sticky protocol error
// -----------------------------------------------------------------------------
module downstream_vc_tracker
   import output_port_tracker_pkg::*;
#(
   parameter int ON_OFF_STAGES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        grant,
   input  logic        grant_multi,
   input  logic        flit_hit,
   input  flit_label_t label,
   input  logic        on_off,
   input  logic        allocatable,
   output logic        free,
   output logic        ready,
   output logic        error
);

   downstream_vc_state_t           state_q;
   downstream_vc_state_t           state_d;
   logic                           seen_low_q;
   logic                           seen_low_d;
   logic                           error_q;
   logic [ON_OFF_STAGES-1:0]       on_sync_q;
   logic                           on_q;
   logic                           grant_ok;
   logic                           flit_ok;
   logic                           err_now;
   logic                           is_head;
   logic                           is_cont;

   assign on_q    = on_sync_q[ON_OFF_STAGES-1];
   assign is_head = (label == HEAD) || (label == HEADTAIL);
   assign is_cont = (label == BODY) || (label == TAIL);

   // A grant is only legal into an IDLE VC and only as part of a one-hot
   // grant vector; a flit is only legal when its label fits the packet phase
   // and the downstream VC was last seen on.
   assign grant_ok = grant && !grant_multi && (state_q == IDLE);
   assign flit_ok  = flit_hit && on_q &&
                     (((state_q == RESERVED) && is_head) ||
                      ((state_q == ACTIVE)   && is_cont));
   assign err_now  = (grant && !grant_ok) || (flit_hit && !flit_ok);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (grant_ok) state_d = RESERVED;
         end
         RESERVED: begin
            if (flit_ok) state_d = (label == HEADTAIL) ? WAIT_RELEASE : ACTIVE;
         end
         ACTIVE: begin
            if (flit_ok && (label == TAIL)) state_d = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            // Release needs proof the downstream VC went busy at some point,
            // otherwise a stale "allocatable" could hand it out twice.
            if (seen_low_q && allocatable) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      seen_low_d = seen_low_q;
      if (state_d == IDLE)
         seen_low_d = 1'b0;
      else if ((state_q != IDLE) && !allocatable)
         seen_low_d = 1'b1;
   end

   // ---- stage p1: state, seen_low, error and on/off sync registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         seen_low_q <= 1'b0;
         error_q    <= 1'b0;
         on_sync_q  <= '0;
      end else begin
         state_q      <= state_d;
         seen_low_q   <= seen_low_d;
         error_q      <= error_q | err_now;
         on_sync_q[0] <= on_off;
         for (int i = 1; i < ON_OFF_STAGES; i++) begin
            on_sync_q[i] <= on_sync_q[i-1];
         end
      end
   end

   assign free  = (state_q == IDLE);
   assign ready = ((state_q == RESERVED) || (state_q == ACTIVE)) && on_q;
   assign error = error_q;

endmodule

// File: rtl/output_port_tracker.sv
// -----------------------------------------------------------------------------
// output_port_tracker
// Transmit side of one router output port: registers the crossbar flit onto
// the link, tracks ownership of each downstream input VC and flags link
// protocol violations. The link is never stalled; erroneous flits still go out.
//   clk   : clock (single domain)
//   rst   : synchronous active-high reset
//   link  : output_port_tracker_if.slave bundle (see interface header)
// Parameters:
//   OUT_REG       : 1 = flit/valid registered onto link, 0 = pass-through
//   ON_OFF_STAGES : sync stages on the downstream on/off inputs (1..2)
// -----------------------------------------------------------------------------
module output_port_tracker
   import output_port_tracker_pkg::*;
#(
   parameter int OUT_REG       = 1,
   parameter int ON_OFF_STAGES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   output_port_tracker_if.slave   link
);

   logic [VC_NUM-1:0] flit_hit;
   logic [VC_NUM-1:0] free_w;
   logic [VC_NUM-1:0] ready_w;
   logic [VC_NUM-1:0] error_w;
   logic              grant_multi;

   assign grant_multi = multi_hot(link.va_grant_i);

   // ---- stage p1: link register ----
   generate
      if (OUT_REG != 0) begin : g_out_reg
         flit_t data_p1;
         logic  vld_p1;

         always_ff @(posedge clk) begin
            if (rst) begin
               data_p1 <= '0;
               vld_p1  <= 1'b0;
            end else begin
               vld_p1 <= link.valid_i;
               // Payload holds across idle cycles; only the valid drops.
               if (link.valid_i) data_p1 <= link.flit_i;
            end
         end

         assign link.data_o       = data_p1;
         assign link.valid_flit_o = vld_p1;
      end else begin : g_out_comb
         assign link.data_o       = link.flit_i;
         assign link.valid_flit_o = link.valid_i;
      end
   endgenerate

   generate
      for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
         assign flit_hit[v] = link.valid_i && (link.flit_i.vc_id == VC_SIZE'(v));

         downstream_vc_tracker #(
            .ON_OFF_STAGES (ON_OFF_STAGES)
         ) u_tracker (
            .clk         (clk),
            .rst         (rst),
            .grant       (link.va_grant_i[v]),
            .grant_multi (grant_multi),
            .flit_hit    (flit_hit[v]),
            .label       (link.flit_i.flit_label),
            .on_off      (link.on_off_i[v]),
            .allocatable (link.allocatable_i[v]),
            .free        (free_w[v]),
            .ready       (ready_w[v]),
            .error       (error_w[v])
         );
      end
   endgenerate

   assign link.vc_allocatable_o = free_w;
   assign link.vc_ready_o       = ready_w;
   assign link.error_o          = error_w;

endmodule

// File: tb/tb_output_port_tracker.sv
// -----------------------------------------------------------------------------
// tb_output_port_tracker
// Scoreboard bench: every driven cycle pushes the expected post-edge outputs
// computed by a packet-level reference model; a monitor pops and compares
// one entry after each rising edge. Directed packets first, then random.
// -----------------------------------------------------------------------------
module tb_output_port_tracker;
   import output_port_tracker_pkg::*;

   localparam int STG = 1;

   typedef struct {
      flit_t             data;
      logic              valid;
      logic [VC_NUM-1:0] alloc;
      logic [VC_NUM-1:0] ready;
      logic [VC_NUM-1:0] err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   output_port_tracker_if bus ();

   output_port_tracker #(
      .OUT_REG       (1),
      .ON_OFF_STAGES (STG)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .link (bus)
   );

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: per VC an ownership phase
   //   0 = free, 1 = reserved (waiting for head), 2 = mid-packet, 3 = draining
   int                ph[VC_NUM];
   bit                went_busy[VC_NUM];
   logic [VC_NUM-1:0] m_err;
   logic [VC_NUM-1:0] on_hist[2];
   flit_t             m_data;

   function automatic flit_t mk(input flit_label_t l, input int vc, input logic [15:0] d);
      flit_t f;
      f.flit_label = l;
      f.vc_id      = VC_SIZE'(vc);
      f.data       = d;
      return f;
   endfunction

   task automatic step(input logic r, input logic v, input flit_t f,
                       input logic [VC_NUM-1:0] g, input logic [VC_NUM-1:0] on,
                       input logic [VC_NUM-1:0] al);
      exp_t e;
      int   ngrant;
      int   nph[VC_NUM];
      @(negedge clk);
      rst               = r;
      bus.valid_i       = v;
      bus.flit_i        = f;
      bus.va_grant_i    = g;
      bus.on_off_i      = on;
      bus.allocatable_i = al;
      if (r) begin
         for (int i = 0; i < VC_NUM; i++) begin
            ph[i] = 0;
            went_busy[i] = 0;
         end
         m_err      = '0;
         on_hist[0] = '0;
         on_hist[1] = '0;
         m_data     = '0;
         e.valid    = 1'b0;
      end else begin
         ngrant = $countones(g);
         for (int i = 0; i < VC_NUM; i++) begin
            logic onq;
            onq    = on_hist[STG-1][i];
            nph[i] = ph[i];
            if (g[i]) begin
               if (ph[i] != 0 || ngrant > 1) m_err[i] = 1'b1;
               else nph[i] = 1;
            end
            if (v && int'(f.vc_id) == i) begin
               if (onq && ph[i] == 1 && (f.flit_label == HEAD || f.flit_label == HEADTAIL))
                  nph[i] = (f.flit_label == HEAD) ? 2 : 3;
               else if (onq && ph[i] == 2 && (f.flit_label == BODY || f.flit_label == TAIL))
                  nph[i] = (f.flit_label == TAIL) ? 3 : 2;
               else
                  m_err[i] = 1'b1;
            end
            if (ph[i] == 3 && went_busy[i] && al[i]) nph[i] = 0;
            if (nph[i] == 0) went_busy[i] = 0;
            else if (ph[i] != 0 && !al[i]) went_busy[i] = 1;
         end
         for (int i = 0; i < VC_NUM; i++) ph[i] = nph[i];
         on_hist[1] = on_hist[0];
         on_hist[0] = on;
         if (v) m_data = f;
         e.valid = v;
      end
      e.data = m_data;
      e.err  = m_err;
      for (int i = 0; i < VC_NUM; i++) begin
         e.alloc[i] = (ph[i] == 0);
         e.ready[i] = (ph[i] == 1 || ph[i] == 2) && on_hist[STG-1][i];
      end
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
      end
   endtask

   // Monitor: compare once per cycle, just after the active edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("valid_flit", 32'(bus.valid_flit_o), 32'(e.valid));
         chk("data", 32'(bus.data_o), 32'(e.data));
         chk("vc_allocatable", 32'(bus.vc_allocatable_o), 32'(e.alloc));
         chk("vc_ready", 32'(bus.vc_ready_o), 32'(e.ready));
         chk("error", 32'(bus.error_o), 32'(e.err));
      end
   end

   initial begin
      flit_t nf;
      flit_t f;
      logic  v;
      logic  r;
      logic [VC_NUM-1:0] g, on, al;
      nf = '0;
      rst = 1'b1;
      bus.valid_i = 1'b0;
      bus.flit_i = '0;
      bus.va_grant_i = '0;
      bus.on_off_i = '0;
      bus.allocatable_i = '0;

      // Reset then idle
      step(1, 0, nf, 2'b00, 2'b00, 2'b11);
      step(1, 0, nf, 2'b00, 2'b00, 2'b11);
      step(0, 0, nf, 2'b00, 2'b11, 2'b11);

      // 3-flit packet on VC 1, downstream busy t3..t6
      step(0, 0, nf, 2'b10, 2'b11, 2'b11);
      step(0, 0, nf, 2'b00, 2'b11, 2'b11);
      step(0, 1, mk(HEAD, 1, 16'hA001), 2'b00, 2'b11, 2'b11);
      step(0, 1, mk(BODY, 1, 16'hA002), 2'b00, 2'b11, 2'b01);
      step(0, 1, mk(TAIL, 1, 16'hA003), 2'b00, 2'b11, 2'b01);
      step(0, 0, nf, 2'b00, 2'b11, 2'b01);
      step(0, 0, nf, 2'b00, 2'b11, 2'b01);
      step(0, 0, nf, 2'b00, 2'b11, 2'b11);
      step(0, 0, nf, 2'b00, 2'b11, 2'b11);

      // HEADTAIL on VC 0: no release until allocatable dips and returns
      step(0, 0, nf, 2'b01, 2'b11, 2'b11);
      step(0, 1, mk(HEADTAIL, 0, 16'hB000), 2'b00, 2'b11, 2'b11);
      repeat (3) step(0, 0, nf, 2'b00, 2'b11, 2'b11);
      step(0, 0, nf, 2'b00, 2'b11, 2'b10);
      step(0, 0, nf, 2'b00, 2'b11, 2'b11);
      step(0, 0, nf, 2'b00, 2'b11, 2'b11);

      // Back-pressure on VC 1, body sent anyway
      step(0, 0, nf, 2'b10, 2'b11, 2'b11);
      step(0, 1, mk(HEAD, 1, 16'hC001), 2'b00, 2'b11, 2'b11);
      step(0, 0, nf, 2'b00, 2'b01, 2'b11);
      step(0, 1, mk(BODY, 1, 16'hC002), 2'b00, 2'b01, 2'b11);
      step(0, 0, nf, 2'b00, 2'b11, 2'b11);

      // Protocol errors
      step(1, 0, nf, 2'b00, 2'b11, 2'b11);
      step(0, 1, mk(HEAD, 0, 16'hD000), 2'b00, 2'b11, 2'b11);
      step(0, 0, nf, 2'b10, 2'b11, 2'b11);
      step(0, 0, nf, 2'b10, 2'b11, 2'b11);
      step(1, 0, nf, 2'b00, 2'b11, 2'b11);
      step(0, 0, nf, 2'b11, 2'b11, 2'b11);
      step(0, 0, nf, 2'b00, 2'b11, 2'b11);
      step(1, 0, nf, 2'b00, 2'b11, 2'b11);

      // Grant and flit together on an IDLE VC
      step(0, 1, mk(BODY, 0, 16'hE000), 2'b01, 2'b11, 2'b11);
      step(1, 0, nf, 2'b00, 2'b11, 2'b11);

      // Reset mid-packet, then a clean packet
      step(0, 0, nf, 2'b10, 2'b11, 2'b11);
      step(0, 1, mk(HEAD, 1, 16'hF001), 2'b00, 2'b11, 2'b11);
      step(1, 1, mk(BODY, 1, 16'hF002), 2'b00, 2'b11, 2'b11);
      step(0, 0, nf, 2'b00, 2'b11, 2'b11);
      step(0, 0, nf, 2'b10, 2'b11, 2'b11);
      step(0, 1, mk(HEAD, 1, 16'hF011), 2'b00, 2'b11, 2'b11);
      step(0, 1, mk(BODY, 1, 16'hF012), 2'b00, 2'b11, 2'b01);
      step(0, 1, mk(TAIL, 1, 16'hF013), 2'b00, 2'b11, 2'b11);
      step(0, 0, nf, 2'b00, 2'b11, 2'b11);

      // Random traffic, biased towards legal packet sequences
      for (int n = 0; n < 3000; n++) begin
         int vc;
         r  = ($urandom_range(0, 79) == 0);
         g  = '0;
         vc = $urandom_range(0, VC_NUM - 1);
         if ($urandom_range(0, 99) < 30 && ph[vc] == 0) g[vc] = 1'b1;
         if ($urandom_range(0, 99) < 3) g = VC_NUM'($urandom);
         v  = ($urandom_range(0, 1) == 1);
         vc = $urandom_range(0, VC_NUM - 1);
         f  = mk(flit_label_t'($urandom_range(0, 3)), vc, 16'($urandom));
         if ($urandom_range(0, 9) != 0) begin
            if (ph[vc] == 1) f.flit_label = $urandom_range(0, 1) ? HEAD : HEADTAIL;
            else if (ph[vc] == 2) f.flit_label = $urandom_range(0, 1) ? BODY : TAIL;
         end
         for (int i = 0; i < VC_NUM; i++) begin
            on[i] = ($urandom_range(0, 99) < 85);
            al[i] = ($urandom_range(0, 99) < 60);
         end
         step(r, v, f, g, on, al);
      end

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
